// File: rtl/fc_pkg.sv
// Shared types and helpers for the Fully_Connected accumulation controller.
// sat_add is only referenced when FC_ACC_SAT_EN is defined.
package fc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } fc_state_t;

    localparam int LANES = 16;

    // Signed saturating add of two w-bit values carried in 64-bit containers.
    // Overflow occurs when both operands share a sign the result lacks.
    function automatic logic [63:0] sat_add(
        input logic [63:0] a,
        input logic [63:0] b,
        input int unsigned w
    );
        logic [63:0] mask;
        logic [63:0] s;
        logic        sa;
        logic        sb;
        logic        ss;
        mask = (64'd1 << w) - 64'd1;
        s    = (a + b) & mask;
        sa   = a[w-1];
        sb   = b[w-1];
        ss   = s[w-1];
        if ((sa == sb) && (ss != sa)) begin
            s = sa ? (64'd1 << (w - 1)) : ((64'd1 << (w - 1)) - 64'd1);
        end
        return s;
    endfunction

endpackage

// File: rtl/fc_accum_ctrl.sv
// Sequencing controller feeding an external 16-lane adder tree and accumulating
// its sum per neuron. Define FC_ACC_SAT_EN for a saturating accumulator add.
module fc_accum_ctrl
    import fc_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int MAX_BEATS  = 64,
    localparam int CNT_W      = $clog2(MAX_BEATS + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [CNT_W-1:0]            num_beats,
    input  logic [DATA_WIDTH-1:0]       bias,
    output logic                        busy,
    input  logic [DATA_WIDTH*LANES-1:0] in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [DATA_WIDTH*LANES-1:0] tree_in,
    input  logic [DATA_WIDTH-1:0]       tree_sum,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        done
);

    fc_state_t             state;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] acc_next;
    logic [CNT_W-1:0]      beat_cnt;
    logic [CNT_W-1:0]      nb_q;

    // Handshake and tree steering follow the state register directly.
    assign in_ready = (state == ACCUM);
    assign tree_in  = in_ready ? in_data : '0;
    assign busy     = (state != IDLE);
    assign out_data = acc;

    // Accumulator adder: wrap-around by default, clamped when saturation is built in.
`ifdef FC_ACC_SAT_EN
    logic [63:0] sat_res;
    always_comb begin
        sat_res  = sat_add({{(64-DATA_WIDTH){1'b0}}, acc},
                           {{(64-DATA_WIDTH){1'b0}}, tree_sum},
                           DATA_WIDTH);
        acc_next = sat_res[DATA_WIDTH-1:0];
    end
`else
    always_comb begin
        acc_next = acc + tree_sum;
    end
`endif

    // Control FSM with counter, accumulator and registered result flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            beat_cnt  <= '0;
            nb_q      <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= bias;
                        nb_q     <= num_beats;
                        beat_cnt <= '0;
                        if (num_beats == '0) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc      <= acc_next;
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == nb_q - 1'b1) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_accum_ctrl.sv
// Directed testbench for fc_accum_ctrl with a behavioural 16-lane adder tree.
// Expectations follow FC_ACC_SAT_EN when it is defined.
module tb_fc_accum_ctrl;

    localparam int DW    = 16;
    localparam int CW    = 7;
    localparam int NL    = 16;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [CW-1:0]   num_beats;
    logic [DW-1:0]   bias;
    logic            busy;
    logic [DW*NL-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic [DW*NL-1:0] tree_in;
    logic [DW-1:0]   tree_sum;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic            done;

    int checks;
    int errors;

    fc_accum_ctrl #(.DATA_WIDTH(DW), .MAX_BEATS(64)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .num_beats(num_beats),
        .bias(bias),
        .busy(busy),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .tree_in(tree_in),
        .tree_sum(tree_sum),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sibling adder tree: wrapping sum of all lanes.
    always_comb begin
        tree_sum = '0;
        for (int k = 0; k < NL; k++) begin
            tree_sum = tree_sum + tree_in[DW*k +: DW];
        end
    end

    function automatic logic [DW*NL-1:0] fill(input logic [DW-1:0] v);
        return {NL{v}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_start(input logic [CW-1:0] nb, input logic [DW-1:0] b);
        start     = 1'b1;
        num_beats = nb;
        bias      = b;
        step();
        start     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        start     = 1'b0;
        num_beats = '0;
        bias      = '0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        settle();
        checks++;
        if ({busy, in_ready, out_valid, done} !== 4'b0000) begin
            $display("FAIL reset_flags got %b want 0000",
                     {busy, in_ready, out_valid, done});
            errors++;
        end
        checks++;
        if (out_data !== 16'd0) begin
            $display("FAIL reset_out_data got %h want 0000", out_data);
            errors++;
        end
    endtask

    task automatic test_normal();
        in_data  = fill(16'd1);
        in_valid = 1'b1;
        do_start(7'd3, 16'd5);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                $display("FAIL normal_ready beat %0d got rdy=%b ov=%b want 1 0",
                         i, in_ready, out_valid);
                errors++;
            end
            if (i == 0) begin
                checks++;
                if (tree_in !== fill(16'd1)) begin
                    $display("FAIL normal_tree_in got %h want all lanes 1",
                             tree_in);
                    errors++;
                end
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'd53 || in_ready !== 1'b0) begin
            $display("FAIL normal_result got ov=%b d=%0d rdy=%b want 1 53 0",
                     out_valid, out_data, in_ready);
            errors++;
        end
        checks++;
        if (tree_in !== '0) begin
            $display("FAIL normal_tree_hold got %h want 0", tree_in);
            errors++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL normal_done got done=%b ov=%b busy=%b want 1 0 0",
                     done, out_valid, busy);
            errors++;
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            $display("FAIL normal_done_pulse got %b want 0", done);
            errors++;
        end
    endtask

    task automatic test_stalls();
        in_data = fill(16'd1);
        do_start(7'd3, 16'd5);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            if (i < 2) begin
                for (int g = 0; g < 2; g++) begin
                    settle();
                    checks++;
                    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                        $display("FAIL stall_gap got rdy=%b ov=%b want 1 0",
                                 in_ready, out_valid);
                        errors++;
                    end
                    step();
                end
            end
        end
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin
                start     = 1'b1;
                num_beats = 7'd1;
                bias      = 16'd0;
            end else begin
                start = 1'b0;
            end
            settle();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'd53 || in_ready !== 1'b0) begin
                $display("FAIL stall_hold c%0d got ov=%b d=%0d rdy=%b want 1 53 0",
                         c, out_valid, out_data, in_ready);
                errors++;
            end
            step();
        end
        start     = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL stall_done got done=%b busy=%b want 1 0", done, busy);
            errors++;
        end
        step();
    endtask

    task automatic test_zero_beats();
        in_valid = 1'b1;
        in_data  = fill(16'd7);
        do_start(7'd0, 16'h1234);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h1234 || in_ready !== 1'b0) begin
            $display("FAIL zero_result got ov=%b d=%h rdy=%b want 1 1234 0",
                     out_valid, out_data, in_ready);
            errors++;
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            $display("FAIL zero_done got %b want 1", done);
            errors++;
        end
        step();
    endtask

    task automatic test_overflow();
        logic [DW-1:0] exp;
`ifdef FC_ACC_SAT_EN
        exp = 16'h7FFF;
`else
        exp = 16'h8000;
`endif
        in_data  = fill(16'd1);
        in_valid = 1'b1;
        do_start(7'd1, 16'h7FF0);
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp) begin
            $display("FAIL overflow got ov=%b d=%h want 1 %h",
                     out_valid, out_data, exp);
            errors++;
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        in_data  = fill(16'd1);
        in_valid = 1'b1;
        do_start(7'd4, 16'd9);
        step();
        step();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        step();
        rst_n = 1'b1;
        settle();
        checks++;
        if ({busy, in_ready, out_valid, done} !== 4'b0000 || out_data !== 16'd0) begin
            $display("FAIL rstmid got flags=%b d=%0d want 0000 0",
                     {busy, in_ready, out_valid, done}, out_data);
            errors++;
        end
        in_data = fill(16'd2);
        do_start(7'd1, 16'd0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'd32) begin
            $display("FAIL rstmid_new got ov=%b d=%0d want 1 32",
                     out_valid, out_data);
            errors++;
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        in_data  = fill(16'd1);
        in_valid = 1'b1;
        do_start(7'd1, 16'd5);
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'd21) begin
            $display("FAIL b2b_first got ov=%b d=%0d want 1 21",
                     out_valid, out_data);
            errors++;
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL b2b_done got done=%b busy=%b want 1 0", done, busy);
            errors++;
        end
        do_start(7'd1, 16'd1);
        settle();
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || done !== 1'b0) begin
            $display("FAIL b2b_restart got busy=%b rdy=%b done=%b want 1 1 0",
                     busy, in_ready, done);
            errors++;
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'd17) begin
            $display("FAIL b2b_second got ov=%b d=%0d want 1 17",
                     out_valid, out_data);
            errors++;
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_normal();
        test_stalls();
        test_zero_beats();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fc_accum_ctrl.md
Name: fc_accum_ctrl

Overview:
- Sequencing controller for the 16-lane combinational adder tree in the Fully_Connected datapath.
- Accepts a stream of 16-lane product vectors with a valid/ready handshake and steers each accepted beat into the tree.
- Accumulates the tree sum over a programmed number of beats on top of a bias, then presents one neuron result through an output valid/ready handshake.
- The tree is a sibling instance: this block drives its input bus and reads its sum.

Parameters:
- DATA_WIDTH, 16, width of each lane, the tree sum, the bias and the accumulator.
- MAX_BEATS, 64, maximum beats per neuron.
- CNT_W (localparam), $clog2(MAX_BEATS+1), width of the beat count and counter.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin a neuron; sampled only in IDLE.
- num_beats  in  CNT_W  beats for this neuron; latched on start.
- bias  in  DATA_WIDTH  initial accumulator value; latched on start.
- busy  out  1  high whenever state != IDLE.
- in_data  in  DATA_WIDTH*16  product vector; lane k at [DW*(k+1)-1:DW*k].
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts a beat.
- tree_in  out  DATA_WIDTH*16  adder-tree input bus.
- tree_sum  in  DATA_WIDTH  adder-tree output (combinational from tree_in).
- out_data  out  DATA_WIDTH  neuron result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- done  out  1  one-cycle pulse after the result handshake.

Behaviour:
- Reset (rst_n low at a clk edge): state goes to IDLE; acc, beat_cnt and the latched num_beats clear to 0; out_valid, done and in_ready go to 0. out_data reads 0. Reset mid-operation abandons the neuron with no output.
- FSM state IDLE: in_ready=0, out_valid=0, tree_in=0.
  - start with num_beats>=1: latch num_beats, acc<=bias, beat_cnt<=0, go to ACCUM.
  - start with num_beats==0: acc<=bias, go to HOLD.
  - num_beats>MAX_BEATS is not supported and is not checked.
- FSM state ACCUM: in_ready=1 and tree_in=in_data, combinationally.
  - Beat accepted (in_valid && in_ready): acc<=acc+tree_sum, beat_cnt++.
  - If beat_cnt==num_beats-1 at acceptance, go to HOLD.
  - in_valid low: hold acc and count. Gaps of any length are allowed.
- FSM state HOLD: in_ready=0, tree_in=0, out_valid=1, out_data=acc (registered).
  - out_data is stable while out_ready is low.
  - On out_ready: go to IDLE; done=1 in the next cycle only.
- start is ignored outside IDLE, including in the handshake cycle.
  - A start in the first IDLE cycle (the done cycle) is honoured. Back-to-back gap is 1 cycle.
- Latency: out_valid rises in the cycle after the last beat is accepted.
- Arithmetic: two's-complement, DATA_WIDTH bits, wraps mod 2^DATA_WIDTH. The tree also wraps internally.

Optional Feature:
- Macro: FC_ACC_SAT_EN.
- Defined: the acc+tree_sum add is signed saturating. It clamps to 2^(DW-1)-1 or -2^(DW-1) on overflow, detected by operand signs vs result sign. Tree-internal wrap is unaffected.
- Undefined: plain wrap-around add.

Decomposition:
- Shared package fc_pkg holds:
  - fc_state_t enum (IDLE, ACCUM, HOLD);
  - LANES=16 constant;
  - sat_add function (used only under FC_ACC_SAT_EN).
- No sub-module: the FSM, counter and accumulator are one module. The tree stays external.

Test Plan (DW=16):
- Normal accumulate: bias=5, num_beats=3, all lanes 1, in_valid held high -> in_ready for 3 cycles; out_valid the next cycle; out_data=53; done pulses one cycle after out_ready.
- Stalls: in_valid gaps of 2 cycles and out_ready low for 4 cycles -> out_data holds 53 throughout; in_ready=0 in HOLD; start pulsed in HOLD is ignored.
- Zero beats: num_beats=0, bias=16'h1234 -> out_valid the cycle after start with out_data=16'h1234; in_ready never high.
- Overflow: bias=16'h7FF0, num_beats=1, all lanes 1 -> out_data=16'h8000 without the macro; 16'h7FFF with FC_ACC_SAT_EN.
- Reset mid-operation: rst_n low after 2 of 4 beats -> busy, in_ready, out_valid and out_data=0; a new start with bias=0, 1 beat of lanes=2 gives 32.
- Back-to-back: start in the done cycle with bias=1, 1 beat of lanes=1 -> second result is 17; no beat lost or duplicated.
